i2s_capture: RTL



---
 rtl/i2s_pkg.sv | 18 +
 rtl/i2s_capture_sync_edge.sv | 29 ++
 rtl/i2s_capture.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S capture/transmit pair: state encoding,
// word-clock polarity and the default sample width.
package i2s_pkg;

    // Receiver frame-tracking states.
    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } i2s_state_e;

    // Word clock level that marks the left channel slot.
    localparam logic LR_LEFT = 1'b0;

    // Default sample width per channel, shared with i2s_tx.
    localparam int I2S_BITSIZE = 16;

endpackage

// File: rtl/i2s_capture_sync_edge.sv
// Two-flop synchroniser with a rising-edge detector on the synchronised
// level. The pulse is high for exactly one clk_i cycle per input rise.
module i2s_sync_edge (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic rise_o
);

    logic meta_q;
    logic sync_q;
    logic dly_q;

    // Metastability stages followed by one delay flop for edge detection.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            dly_q  <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            dly_q  <= sync_q;
        end
    end

    assign rise_o = sync_q & ~dly_q;

endmodule

// File: rtl/i2s_capture.sv
// I2S receiver: oversamples BCLK/ADCLRC/ADCDAT in the clk domain and presents
// left/right samples with a one-cycle valid strobe once a full pair is in.
//
// state | meaning
// ------+---------------------------------------------------------------
// SYNC  | not tracking; waiting for the first word-clock transition
// LEFT  | shifting bits of the left-channel word (lrclk low)
// RIGHT | shifting bits of the right-channel word (lrclk high)
module i2s_capture
    import i2s_pkg::*;
#(
    parameter int BITSIZE = I2S_BITSIZE,
    parameter int TIMEOUT = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      bclk,
    input  logic                      lrclk,
    input  logic                      sdata,
    output logic signed [BITSIZE-1:0] left_chan,
    output logic signed [BITSIZE-1:0] right_chan,
    output logic                      valid,
    output logic                      short_err,
    output logic                      locked
);

    localparam int CW = $clog2(BITSIZE + 1);
    localparam int WW = $clog2(TIMEOUT + 1);

    logic              brise;
    logic [1:0]        in_meta_q;
    logic [1:0]        in_sync_q;
    logic              lr_s;
    logic              sd_s;

    i2s_state_e        state_q;
    logic [BITSIZE-1:0] shift_q;
    logic [CW-1:0]     cnt_q;
    logic              lr_prev_q;
    logic              lr_ok_q;
    logic              left_seen_q;
    logic [BITSIZE-1:0] left_q;
    logic [BITSIZE-1:0] right_q;
    logic              valid_q;
    logic              short_q;
    logic              locked_q;
    logic [WW-1:0]     wd_q;

    logic              edge_det;
    logic              cnt_full;
    logic              wd_expire;
    logic [BITSIZE-1:0] shift_ins;
    logic [BITSIZE-1:0] word_d;
    logic [CW-1:0]     fill_cnt;
    logic              short_d;

    i2s_sync_edge u_bclk_sync (
        .clk_i  (clk),
        .rst_i  (rst),
        .d_i    (bclk),
        .rise_o (brise)
    );

    // Plain two-flop synchronisers for word clock and data; they line up
    // with the bclk path so both are stable when brise is seen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_meta_q <= 2'b00;
            in_sync_q <= 2'b00;
        end else begin
            in_meta_q <= {lrclk, sdata};
            in_sync_q <= in_meta_q;
        end
    end

    assign lr_s = in_sync_q[1];
    assign sd_s = in_sync_q[0];

    // lr_ok_q gates the first brise after reset/timeout so a stale lr_prev
    // cannot fake a transition when the stream starts mid-slot.
    assign edge_det  = brise && lr_ok_q && (lr_s != lr_prev_q);
    assign cnt_full  = (cnt_q >= CW'(BITSIZE));
    assign shift_ins = {shift_q[BITSIZE-2:0], sd_s};

    // Outgoing word on a transition: take the delay-slot bit if there is
    // room, then left-justify with zero LSBs if the slot came up short.
    always_comb begin
        word_d   = shift_q;
        fill_cnt = cnt_q;
        if (!cnt_full) begin
            word_d   = shift_ins;
            fill_cnt = cnt_q + 1'b1;
        end
        short_d = (fill_cnt < CW'(BITSIZE));
        if (short_d) begin
            word_d = word_d << (CW'(BITSIZE) - fill_cnt);
        end
    end

    // Watchdog: reloads on every brise, expires after TIMEOUT quiet cycles.
    // A brise in the expiry cycle wins because expiry requires !brise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_q <= '0;
        end else if (brise) begin
            wd_q <= WW'(TIMEOUT);
        end else if (wd_q != '0) begin
            wd_q <= wd_q - 1'b1;
        end
    end

    assign wd_expire = !brise && (wd_q == WW'(1));

    // Frame tracking, deserialisation and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= SYNC;
            shift_q     <= '0;
            cnt_q       <= '0;
            lr_prev_q   <= LR_LEFT;
            lr_ok_q     <= 1'b0;
            left_seen_q <= 1'b0;
            left_q      <= '0;
            right_q     <= '0;
            valid_q     <= 1'b0;
            short_q     <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            short_q <= 1'b0;
            if (brise) begin
                lr_prev_q <= lr_s;
                lr_ok_q   <= 1'b1;
                if (edge_det) begin
                    shift_q <= '0;
                    cnt_q   <= '0;
                    case (state_q)
                        SYNC: begin
                            locked_q <= 1'b1;
                            state_q  <= (lr_s == LR_LEFT) ? LEFT : RIGHT;
                        end
                        default: begin
                            short_q <= short_d;
                            if (lr_s != LR_LEFT) begin
                                left_q      <= word_d;
                                left_seen_q <= 1'b1;
                                state_q     <= RIGHT;
                            end else begin
                                right_q     <= word_d;
                                valid_q     <= left_seen_q;
                                left_seen_q <= 1'b0;
                                state_q     <= LEFT;
                            end
                        end
                    endcase
                end else if (state_q != SYNC && !cnt_full) begin
                    shift_q <= shift_ins;
                    cnt_q   <= cnt_q + 1'b1;
                end
            end else if (wd_expire) begin
                state_q     <= SYNC;
                locked_q    <= 1'b0;
                cnt_q       <= '0;
                shift_q     <= '0;
                left_seen_q <= 1'b0;
                lr_ok_q     <= 1'b0;
            end
        end
    end

    assign left_chan  = left_q;
    assign right_chan = right_q;
    assign valid      = valid_q;
    assign short_err  = short_q;
    assign locked     = locked_q;

endmodule
